// File: rtl/ex_mem_pipe.sv
// EX->MEM pipeline register with bubble/flush/hold control and an EX multi-cycle feedback path.
// Optional exception fields are enabled by defining EX_MEM_EXC_EN.
module ex_mem_pipe #(
  parameter int DATA_W     = 32,
  parameter int REG_ADDR_W = 5,
  parameter int ALUOP_W    = 8,
  parameter int CNT_W      = 2,
  parameter int STALL_W    = 6,
  parameter int STAGE_IDX  = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [STALL_W-1:0]    stall,
  input  logic                  flush,
  input  logic                  ex_valid,
  input  logic [REG_ADDR_W-1:0] ex_wd,
  input  logic                  ex_wreg,
  input  logic [DATA_W-1:0]     ex_wdata,
  input  logic                  ex_whilo,
  input  logic [DATA_W-1:0]     ex_hi,
  input  logic [DATA_W-1:0]     ex_lo,
  input  logic [ALUOP_W-1:0]    ex_aluop,
  input  logic [DATA_W-1:0]     ex_mem_addr,
  input  logic [DATA_W-1:0]     ex_reg2,
  input  logic [2*DATA_W-1:0]   hilo_i,
  input  logic [CNT_W-1:0]      cnt_i,
`ifdef EX_MEM_EXC_EN
  input  logic [31:0]           ex_excepttype,
  input  logic [DATA_W-1:0]     ex_inst_addr,
  input  logic                  ex_in_delayslot,
  output logic [31:0]           mem_excepttype,
  output logic [DATA_W-1:0]     mem_inst_addr,
  output logic                  mem_in_delayslot,
`endif
  output logic                  mem_valid,
  output logic [REG_ADDR_W-1:0] mem_wd,
  output logic                  mem_wreg,
  output logic [DATA_W-1:0]     mem_wdata,
  output logic                  mem_whilo,
  output logic [DATA_W-1:0]     mem_hi,
  output logic [DATA_W-1:0]     mem_lo,
  output logic [ALUOP_W-1:0]    mem_aluop,
  output logic [DATA_W-1:0]     mem_mem_addr,
  output logic [DATA_W-1:0]     mem_reg2,
  output logic [2*DATA_W-1:0]   hilo_o,
  output logic [CNT_W-1:0]      cnt_o
);

  typedef struct packed {
    logic                  valid;
    logic [REG_ADDR_W-1:0] wd;
    logic                  wreg;
    logic [DATA_W-1:0]     wdata;
    logic                  whilo;
    logic [DATA_W-1:0]     hi;
    logic [DATA_W-1:0]     lo;
    logic [ALUOP_W-1:0]    aluop;
    logic [DATA_W-1:0]     mem_addr;
    logic [DATA_W-1:0]     reg2;
`ifdef EX_MEM_EXC_EN
    logic [31:0]           excepttype;
    logic [DATA_W-1:0]     inst_addr;
    logic                  in_delayslot;
`endif
  } bundle_t;

  bundle_t               w_ex;
  bundle_t               r_mem;
  logic [2*DATA_W-1:0]   r_hilo;
  logic [CNT_W-1:0]      r_cnt;
  logic                  w_s;
  logic                  w_n;

  assign w_s = stall[STAGE_IDX];
  assign w_n = stall[STAGE_IDX+1];

  assign w_ex.valid    = ex_valid;
  assign w_ex.wd       = ex_wd;
  assign w_ex.wreg     = ex_wreg;
  assign w_ex.wdata    = ex_wdata;
  assign w_ex.whilo    = ex_whilo;
  assign w_ex.hi       = ex_hi;
  assign w_ex.lo       = ex_lo;
  assign w_ex.aluop    = ex_aluop;
  assign w_ex.mem_addr = ex_mem_addr;
  assign w_ex.reg2     = ex_reg2;
`ifdef EX_MEM_EXC_EN
  assign w_ex.excepttype   = ex_excepttype;
  assign w_ex.inst_addr    = ex_inst_addr;
  assign w_ex.in_delayslot = ex_in_delayslot;
`endif

  // Pipeline register: reset > flush > bubble (loads feedback) > capture > full hold.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_mem  <= '0;
      r_hilo <= '0;
      r_cnt  <= '0;
    end else if (flush) begin
      r_mem  <= '0;
      r_hilo <= '0;
      r_cnt  <= '0;
    end else if (w_s && !w_n) begin
      r_mem  <= '0;
      r_hilo <= hilo_i;
      r_cnt  <= cnt_i;
    end else if (!w_s) begin
      r_mem  <= w_ex;
      r_hilo <= '0;
      r_cnt  <= '0;
    end else begin
      r_mem  <= r_mem;
      r_hilo <= r_hilo;
      r_cnt  <= r_cnt;
    end
  end

  assign mem_valid    = r_mem.valid;
  assign mem_wd       = r_mem.wd;
  assign mem_wreg     = r_mem.wreg;
  assign mem_wdata    = r_mem.wdata;
  assign mem_whilo    = r_mem.whilo;
  assign mem_hi       = r_mem.hi;
  assign mem_lo       = r_mem.lo;
  assign mem_aluop    = r_mem.aluop;
  assign mem_mem_addr = r_mem.mem_addr;
  assign mem_reg2     = r_mem.reg2;
  assign hilo_o       = r_hilo;
  assign cnt_o        = r_cnt;
`ifdef EX_MEM_EXC_EN
  assign mem_excepttype   = r_mem.excepttype;
  assign mem_inst_addr    = r_mem.inst_addr;
  assign mem_in_delayslot = r_mem.in_delayslot;
`endif

  ex_mem_pipe_chk #(
    .STALL_W   (STALL_W),
    .STAGE_IDX (STAGE_IDX)
  ) u_chk (
    .clk   (clk),
    .rst   (rst),
    .stall (stall)
  );

endmodule

// Flags stall vectors the control unit must never produce (EX running while MEM is stopped).
module ex_mem_pipe_chk #(
  parameter int STALL_W   = 6,
  parameter int STAGE_IDX = 3
) (
  input logic               clk,
  input logic               rst,
  input logic [STALL_W-1:0] stall
);

  // Checks the stall vector every cycle outside reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      assert (!$isunknown(stall)) else $error("ex_mem_pipe: stall vector unknown");
      assert (!(!stall[STAGE_IDX] && stall[STAGE_IDX+1]))
        else $error("ex_mem_pipe: illegal stall pattern EX running, MEM stopped");
    end
  end

endmodule

// File: tb/tb_ex_mem_pipe.sv
// Randomised self-checking bench for ex_mem_pipe against a rule-level reference model.
module tb_ex_mem_pipe;

  typedef struct packed {
    logic        valid;
    logic [4:0]  wd;
    logic        wreg;
    logic [31:0] wdata;
    logic        whilo;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [7:0]  aluop;
    logic [31:0] addr;
    logic [31:0] reg2;
`ifdef EX_MEM_EXC_EN
    logic [31:0] exc;
    logic [31:0] iaddr;
    logic        ds;
`endif
  } bun_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  stall;
  logic        flush;
  bun_t        drv;
  logic [63:0] hilo_i;
  logic [1:0]  cnt_i;

  bun_t        dut_b;
  logic [63:0] hilo_o;
  logic [1:0]  cnt_o;

  bun_t        m_mem;
  logic [63:0] m_hilo;
  logic [1:0]  m_cnt;

  int checks = 0;
  int errors = 0;
  bit run = 1'b0;

  always #5 clk = ~clk;

  ex_mem_pipe dut (
    .clk          (clk),
    .rst          (rst),
    .stall        (stall),
    .flush        (flush),
    .ex_valid     (drv.valid),
    .ex_wd        (drv.wd),
    .ex_wreg      (drv.wreg),
    .ex_wdata     (drv.wdata),
    .ex_whilo     (drv.whilo),
    .ex_hi        (drv.hi),
    .ex_lo        (drv.lo),
    .ex_aluop     (drv.aluop),
    .ex_mem_addr  (drv.addr),
    .ex_reg2      (drv.reg2),
    .hilo_i       (hilo_i),
    .cnt_i        (cnt_i),
`ifdef EX_MEM_EXC_EN
    .ex_excepttype    (drv.exc),
    .ex_inst_addr     (drv.iaddr),
    .ex_in_delayslot  (drv.ds),
    .mem_excepttype   (dut_b.exc),
    .mem_inst_addr    (dut_b.iaddr),
    .mem_in_delayslot (dut_b.ds),
`endif
    .mem_valid    (dut_b.valid),
    .mem_wd       (dut_b.wd),
    .mem_wreg     (dut_b.wreg),
    .mem_wdata    (dut_b.wdata),
    .mem_whilo    (dut_b.whilo),
    .mem_hi       (dut_b.hi),
    .mem_lo       (dut_b.lo),
    .mem_aluop    (dut_b.aluop),
    .mem_mem_addr (dut_b.addr),
    .mem_reg2     (dut_b.reg2),
    .hilo_o       (hilo_o),
    .cnt_o        (cnt_o)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Reference model: what MEM should hold after each edge, from the stage-control rules.
  always @(posedge clk) begin
    if (!rst || flush) begin
      m_mem <= '0; m_hilo <= '0; m_cnt <= '0;
    end else if (stall[3] && !stall[4]) begin
      m_mem <= '0; m_hilo <= hilo_i; m_cnt <= cnt_i;
    end else if (!stall[3]) begin
      m_mem <= drv; m_hilo <= '0; m_cnt <= '0;
    end
  end

  // Compare process: every cycle once the model has seen its first reset edge.
  always @(negedge clk) begin
    if (run) begin
      chk("valid", 64'(dut_b.valid), 64'(m_mem.valid));
      chk("wd",    64'(dut_b.wd),    64'(m_mem.wd));
      chk("wreg",  64'(dut_b.wreg),  64'(m_mem.wreg));
      chk("wdata", 64'(dut_b.wdata), 64'(m_mem.wdata));
      chk("whilo", 64'(dut_b.whilo), 64'(m_mem.whilo));
      chk("hi",    64'(dut_b.hi),    64'(m_mem.hi));
      chk("lo",    64'(dut_b.lo),    64'(m_mem.lo));
      chk("aluop", 64'(dut_b.aluop), 64'(m_mem.aluop));
      chk("addr",  64'(dut_b.addr),  64'(m_mem.addr));
      chk("reg2",  64'(dut_b.reg2),  64'(m_mem.reg2));
      chk("hilo_o", hilo_o,          m_hilo);
      chk("cnt_o", 64'(cnt_o),       64'(m_cnt));
`ifdef EX_MEM_EXC_EN
      chk("exc",   64'(dut_b.exc),   64'(m_mem.exc));
      chk("iaddr", 64'(dut_b.iaddr), 64'(m_mem.iaddr));
      chk("ds",    64'(dut_b.ds),    64'(m_mem.ds));
`endif
    end
  end

  task automatic rand_ex();
    drv.valid = 1'($urandom);
    drv.wd    = 5'($urandom);
    drv.wreg  = 1'($urandom);
    drv.wdata = $urandom;
    drv.whilo = 1'($urandom);
    drv.hi    = $urandom;
    drv.lo    = $urandom;
    drv.aluop = 8'($urandom);
    drv.addr  = $urandom;
    drv.reg2  = $urandom;
`ifdef EX_MEM_EXC_EN
    drv.exc   = $urandom;
    drv.iaddr = $urandom;
    drv.ds    = 1'($urandom);
`endif
    hilo_i = {$urandom, $urandom};
    cnt_i  = 2'($urandom);
  endtask

  initial begin
    rst = 1'b0; flush = 1'b0; stall = 6'b000000;
    drv = '0; hilo_i = 64'h0; cnt_i = 2'd0;
    drv.wdata = 32'hDEADBEEF; drv.wreg = 1'b1; drv.valid = 1'b1;
    @(posedge clk); #1 run = 1'b1;

    // Reset held for two edges
    @(negedge clk); @(negedge clk);
    chk("rst_wdata", 64'(dut_b.wdata), 64'h0);
    chk("rst_wreg",  64'(dut_b.wreg),  64'h0);
    rst = 1'b1;
    @(negedge clk);
    chk("post_rst_wdata", 64'(dut_b.wdata), 64'hDEADBEEF);
    chk("post_rst_wreg",  64'(dut_b.wreg),  64'h1);
    chk("post_rst_valid", 64'(dut_b.valid), 64'h1);

    // Bubble loads the feedback path
    stall = 6'b001111; hilo_i = 64'h1_0000_0002; cnt_i = 2'd1;
    @(negedge clk);
    chk("bub_wreg",  64'(dut_b.wreg),  64'h0);
    chk("bub_valid", 64'(dut_b.valid), 64'h0);
    chk("bub_hilo",  hilo_o,           64'h1_0000_0002);
    chk("bub_cnt",   64'(cnt_o),       64'h1);
    stall = 6'b000000; drv.wd = 5'd7;
    @(negedge clk);
    chk("resume_wd",   64'(dut_b.wd), 64'h7);
    chk("resume_hilo", hilo_o,        64'h0);
    chk("resume_cnt",  64'(cnt_o),    64'h0);

    // Full hold while EX inputs toggle
    drv.wd = 5'd9; drv.hi = 32'h55;
    @(negedge clk);
    stall = 6'b011111;
    for (int i = 0; i < 3; i++) begin
      rand_ex();
      @(negedge clk);
      chk("hold_wd",   64'(dut_b.wd), 64'h9);
      chk("hold_hi",   64'(dut_b.hi), 64'h55);
      chk("hold_hilo", hilo_o,        64'h0);
    end

    // Flush beats a bubble stall pattern
    stall = 6'b001111; hilo_i = 64'hABCD_0000_1234; cnt_i = 2'd3; flush = 1'b1;
    @(negedge clk);
    chk("flush_wd",   64'(dut_b.wd),   64'h0);
    chk("flush_wreg", 64'(dut_b.wreg), 64'h0);
    chk("flush_hilo", hilo_o,          64'h0);
    chk("flush_cnt",  64'(cnt_o),      64'h0);
    flush = 1'b0;

    // Store path
    stall = 6'b000000;
    drv.aluop = 8'h2B; drv.addr = 32'h0000_1004; drv.reg2 = 32'hCAFE_F00D;
    @(negedge clk);
    chk("st_aluop", 64'(dut_b.aluop), 64'h2B);
    chk("st_addr",  64'(dut_b.addr),  64'h1004);
    chk("st_reg2",  64'(dut_b.reg2),  64'hCAFE_F00D);

`ifdef EX_MEM_EXC_EN
    drv.exc = 32'h0000_0008; drv.ds = 1'b1;
    @(negedge clk);
    chk("exc_pass", 64'(dut_b.exc), 64'h8);
    chk("ds_pass",  64'(dut_b.ds),  64'h1);
    flush = 1'b1;
    @(negedge clk);
    chk("exc_flush", 64'(dut_b.exc), 64'h0);
    flush = 1'b0;
`endif

    // Random traffic over legal stall patterns, occasional flush and reset
    for (int c = 0; c < 400; c++) begin
      rand_ex();
      stall = 6'($urandom);
      if (!stall[3] && stall[4]) stall[4] = 1'b0;
      flush = ($urandom_range(0, 7) == 0);
      rst   = ($urandom_range(0, 31) != 0);
      @(negedge clk);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
